// File: rtl/eth_phy_10g_pkg.sv
// Shared types and constants for the 10G PHY rx link controller.
package eth_phy_10g_pkg;

  // Link controller FSM states; encodings are visible on the state port.
  typedef enum logic [2:0] {
    ST_DISABLED    = 3'd0,
    ST_RESET       = 3'd1,
    ST_WAIT_LOCK   = 3'd2,
    ST_WAIT_STABLE = 3'd3,
    ST_LINK_UP     = 3'd4,
    ST_PRBS        = 3'd5
  } link_state_e;

  localparam int ERR_TOTAL_WIDTH = 32;
  localparam int PHY_ERR_WIDTH   = 7;

  // A receive cycle counts as good only with lock, status and no high BER.
  function automatic logic is_rx_good(input logic block_lock,
                                      input logic status,
                                      input logic high_ber);
    return block_lock & status & ~high_ber;
  endfunction

endpackage

// File: rtl/eth_sat_counter.sv
// Saturating accumulator with synchronous clear; clear wins over a
// same-cycle add.
module eth_sat_counter #(
  parameter int WIDTH     = 8,
  parameter int INC_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 inc_en,
  input  logic [INC_WIDTH-1:0] inc_val,
  output logic [WIDTH-1:0]     count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH:0]   sum_s;

  // Next count: clear, saturating add, or hold.
  always_comb begin
    sum_s   = {1'b0, count_q} + {{(WIDTH + 1 - INC_WIDTH){1'b0}}, inc_val};
    count_d = count_q;
    if (clear) begin
      count_d = {WIDTH{1'b0}};
    end else if (inc_en) begin
      if (sum_s[WIDTH]) begin
        count_d = {WIDTH{1'b1}};
      end else begin
        count_d = sum_s[WIDTH-1:0];
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/eth_phy_10g_link_ctrl.sv
// 10G PHY rx link bring-up / supervision controller.
// Optional PRBS31 test mode is compiled in with ETH_PHY_LINK_CTRL_PRBS_EN.
module eth_phy_10g_link_ctrl
  import eth_phy_10g_pkg::*;
#(
  parameter int RESET_CYCLES  = 64,
  parameter int LOCK_TIMEOUT  = 1048576,
  parameter int STABLE_CYCLES = 4096,
  parameter int TIMER_WIDTH   = 21,
  parameter int RETRY_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       clear_counters,
  input  logic                       phy_rx_block_lock,
  input  logic                       phy_rx_high_ber,
  input  logic                       phy_rx_status,
  input  logic [PHY_ERR_WIDTH-1:0]   phy_rx_error_count,
  input  logic                       phy_rx_reset_req,
  output logic                       serdes_rx_reset,
  output logic                       link_up,
  output logic                       link_down_event,
  output logic [2:0]                 state,
  output logic [RETRY_WIDTH-1:0]     retry_count,
  output logic [ERR_TOTAL_WIDTH-1:0] error_total,
  input  logic                       cfg_prbs_enable,
  output logic                       phy_tx_prbs31_enable,
  output logic                       phy_rx_prbs31_enable
);

  localparam logic [TIMER_WIDTH-1:0] RESET_LAST  = TIMER_WIDTH'(RESET_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] LOCK_LAST   = TIMER_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] STABLE_LAST = TIMER_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] T_ZERO      = {TIMER_WIDTH{1'b0}};
  localparam logic [TIMER_WIDTH-1:0] T_ONE       = TIMER_WIDTH'(1);

  link_state_e            state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [TIMER_WIDTH-1:0] stable_q, stable_d;
  logic                   serdes_rx_reset_q, serdes_rx_reset_d;
  logic                   link_up_q, link_up_d;
  logic                   link_down_event_q, link_down_event_d;
  logic                   prbs_q, prbs_d;
  logic                   retry_inc_s;
  logic                   err_add_en_s;
  logic                   rx_good_s;

  assign rx_good_s = is_rx_good(phy_rx_block_lock, phy_rx_status, phy_rx_high_ber);

  // Next-state logic; the WAIT_LOCK/WAIT_STABLE timer is shared so the
  // lock timeout bounds the whole bring-up, and a timeout beats lock/link-up.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    stable_d    = stable_q;
    retry_inc_s = 1'b0;
    if (!enable) begin
      state_d  = ST_DISABLED;
      timer_d  = T_ZERO;
      stable_d = T_ZERO;
    end else if (phy_rx_reset_req) begin
      state_d     = ST_RESET;
      timer_d     = T_ZERO;
      stable_d    = T_ZERO;
      retry_inc_s = 1'b1;
    end else begin
      case (state_q)
        ST_DISABLED: begin
          state_d = ST_RESET;
          timer_d = T_ZERO;
        end
        ST_RESET: begin
          if (timer_q == RESET_LAST) begin
            state_d = ST_WAIT_LOCK;
            timer_d = T_ZERO;
          end else begin
            timer_d = timer_q + T_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (timer_q == LOCK_LAST) begin
            state_d     = ST_RESET;
            timer_d     = T_ZERO;
            retry_inc_s = 1'b1;
          end else begin
            timer_d = timer_q + T_ONE;
            if (phy_rx_block_lock) begin
              state_d  = ST_WAIT_STABLE;
              stable_d = T_ZERO;
            end else begin
              state_d = ST_WAIT_LOCK;
            end
          end
        end
        ST_WAIT_STABLE: begin
          if (timer_q == LOCK_LAST) begin
            state_d     = ST_RESET;
            timer_d     = T_ZERO;
            retry_inc_s = 1'b1;
          end else begin
            timer_d = timer_q + T_ONE;
            if (!phy_rx_block_lock) begin
              state_d = ST_WAIT_LOCK;
            end else if (rx_good_s) begin
              if (stable_q == STABLE_LAST) begin
                state_d = ST_LINK_UP;
              end else begin
                stable_d = stable_q + T_ONE;
              end
            end else begin
              stable_d = T_ZERO;
            end
          end
        end
        ST_LINK_UP: begin
          timer_d = T_ZERO;
          if (!phy_rx_block_lock || !phy_rx_status) begin
            state_d = ST_WAIT_LOCK;
`ifdef ETH_PHY_LINK_CTRL_PRBS_EN
          end else if (cfg_prbs_enable) begin
            state_d = ST_PRBS;
`endif
          end else begin
            state_d = ST_LINK_UP;
          end
        end
`ifdef ETH_PHY_LINK_CTRL_PRBS_EN
        ST_PRBS: begin
          timer_d = T_ZERO;
          if (!cfg_prbs_enable) begin
            state_d = ST_RESET;
          end else begin
            state_d = ST_PRBS;
          end
        end
`endif
        default: begin
          state_d  = ST_DISABLED;
          timer_d  = T_ZERO;
          stable_d = T_ZERO;
        end
      endcase
    end
  end

  // Output values that go with the next state, registered below.
  always_comb begin
    serdes_rx_reset_d = (state_d == ST_DISABLED) || (state_d == ST_RESET);
    link_up_d         = (state_d == ST_LINK_UP) || (state_d == ST_PRBS);
    link_down_event_d = (state_q == ST_LINK_UP) && (state_d != ST_LINK_UP) &&
                        (state_d != ST_PRBS);
`ifdef ETH_PHY_LINK_CTRL_PRBS_EN
    prbs_d            = (state_d == ST_PRBS);
`else
    prbs_d            = 1'b0;
`endif
    err_add_en_s      = (state_q == ST_WAIT_STABLE) || (state_q == ST_LINK_UP) ||
                        (state_q == ST_PRBS);
  end

  // FSM state, timers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_DISABLED;
      timer_q           <= T_ZERO;
      stable_q          <= T_ZERO;
      serdes_rx_reset_q <= 1'b1;
      link_up_q         <= 1'b0;
      link_down_event_q <= 1'b0;
      prbs_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      timer_q           <= timer_d;
      stable_q          <= stable_d;
      serdes_rx_reset_q <= serdes_rx_reset_d;
      link_up_q         <= link_up_d;
      link_down_event_q <= link_down_event_d;
      prbs_q            <= prbs_d;
    end
  end

`ifndef ETH_PHY_LINK_CTRL_PRBS_EN
  logic unused_cfg_prbs_s;
  assign unused_cfg_prbs_s = cfg_prbs_enable;
`endif

  eth_sat_counter #(.WIDTH(RETRY_WIDTH), .INC_WIDTH(1)) u_retry_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_counters),
    .inc_en  (retry_inc_s),
    .inc_val (1'b1),
    .count   (retry_count)
  );

  eth_sat_counter #(.WIDTH(ERR_TOTAL_WIDTH), .INC_WIDTH(PHY_ERR_WIDTH)) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_counters),
    .inc_en  (err_add_en_s),
    .inc_val (phy_rx_error_count),
    .count   (error_total)
  );

  assign serdes_rx_reset      = serdes_rx_reset_q;
  assign link_up              = link_up_q;
  assign link_down_event      = link_down_event_q;
  assign state                = state_q;
  assign phy_tx_prbs31_enable = prbs_q;
  assign phy_rx_prbs31_enable = prbs_q;

endmodule

// File: doc/eth_phy_10g_link_ctrl.md
Name: eth_phy_10g_link_ctrl

Overview:
- Link bring-up and supervision controller for the 10G PHY (rx side).
- Holds the SERDES RX in reset, then waits for block lock and a stable rx_status, then declares link up.
- After link up, supervises the link and retries bring-up with timeouts and a retry counter.
- Accumulates the PHY per-cycle error count into a statistics counter; sits between the PHY status outputs and the SERDES reset/config inputs.

Parameters:
- RESET_CYCLES, 64: cycles serdes_rx_reset is held in RESET state (>=1).
- LOCK_TIMEOUT, 1048576: max cycles spent in WAIT_LOCK+WAIT_STABLE before re-reset (>=2).
- STABLE_CYCLES, 4096: consecutive good-status cycles required before LINK_UP (>=1).
- TIMER_WIDTH, 21: timer width; must hold max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)-1.
- RETRY_WIDTH, 8: width of the saturating retry counter.

Ports:
- clk  in  1  single clock (PHY rx clock domain)
- rst  in  1  asynchronous, active-high reset
- enable  in  1  0 forces DISABLED
- clear_counters  in  1  synchronous clear of retry_count and error_total
- phy_rx_block_lock  in  1  PHY block lock
- phy_rx_high_ber  in  1  PHY high BER flag
- phy_rx_status  in  1  PHY link status
- phy_rx_error_count  in  7  PHY errors this cycle
- phy_rx_reset_req  in  1  PHY request to reset the SERDES
- serdes_rx_reset  out  1  SERDES RX reset
- link_up  out  1  1 only in LINK_UP (or PRBS, see below)
- link_down_event  out  1  one-cycle pulse on leaving LINK_UP
- state  out  3  current FSM state encoding
- retry_count  out  RETRY_WIDTH  saturating count of re-resets
- error_total  out  32  saturating error accumulator
- cfg_prbs_enable  in  1  PRBS test request (used only with the macro)
- phy_tx_prbs31_enable  out  1  to PHY tx
- phy_rx_prbs31_enable  out  1  to PHY rx

Behaviour:
- Reset behaviour: clock is clk; reset rst is asynchronous, active-high.
- Reset values: state=DISABLED(0), serdes_rx_reset=1, link_up=0, link_down_event=0, retry_count=0, error_total=0, prbs enables=0, timer=0.
- All outputs are registered; an output reflects a transition on the cycle after the causing input is sampled.
- State encodings: DISABLED=0, RESET=1, WAIT_LOCK=2, WAIT_STABLE=3, LINK_UP=4, PRBS=5.
- Transition priority, highest first: enable=0 (-> DISABLED) > phy_rx_reset_req (-> RESET, retry++) > per-state rules below.
- DISABLED: serdes_rx_reset=1. When enable=1 -> RESET with timer=0. Does not increment retry.
- RESET: serdes_rx_reset=1. Timer counts up. At timer==RESET_CYCLES-1 -> WAIT_LOCK with timer=0. serdes_rx_reset is therefore high for exactly RESET_CYCLES cycles.
- WAIT_LOCK: serdes_rx_reset=0, timer counts up.
  - block_lock=1 -> WAIT_STABLE; timer continues and a separate stable counter is set to 0.
  - timer==LOCK_TIMEOUT-1 -> RESET, retry++.
- WAIT_STABLE: "good" means block_lock & status & !high_ber.
  - Stable counter increments while good and resets to 0 when not good.
  - Stable counter reaches STABLE_CYCLES-1 while good -> LINK_UP.
  - block_lock=0 -> WAIT_LOCK; the shared timer is NOT cleared.
  - Shared timer hits LOCK_TIMEOUT-1 -> RESET, retry++; this timeout takes priority over the LINK_UP transition on the same cycle.
- LINK_UP: link_up=1.
  - block_lock=0 or status=0 -> WAIT_LOCK with timer=0, link_down_event=1 for one cycle.
  - high_ber alone does not drop the link (status already covers it).
  - Exits to RESET or DISABLED from LINK_UP also pulse link_down_event.
- retry_count: increments by 1, saturates at all-ones.
- error_total: adds phy_rx_error_count in WAIT_STABLE, LINK_UP and PRBS; saturates at 2^32-1, no wrap.
- clear_counters: both counters become 0 next cycle. A clear beats a same-cycle increment/add, whose value is discarded.
- A mid-operation rst returns every register to its reset value immediately (asynchronously).

Optional Feature:
- Macro: ETH_PHY_LINK_CTRL_PRBS_EN.
- Defined:
  - In LINK_UP, cfg_prbs_enable=1 -> PRBS.
  - PRBS: phy_tx_prbs31_enable=phy_rx_prbs31_enable=1, link_up=1, block_lock/status are ignored, and errors accumulate.
  - cfg_prbs_enable=0 -> RESET, with no retry increment.
  - enable=0 and phy_rx_reset_req keep their priority in PRBS.
- Undefined: cfg_prbs_enable is ignored, the prbs outputs are tied 0, and state 5 is unreachable.

Decomposition:
- Shared package eth_phy_10g_pkg holds:
  - the state enum (3-bit, encodings above);
  - the saturating-add width constant (ERR_TOTAL_WIDTH=32);
  - PHY error-count width 7.
- One sub-module: eth_sat_counter (parametrised width, increment input, clear input, saturate), instantiated for retry_count and error_total.

Test Plan:
- Release rst with enable=1 and block_lock tied 1, status 1 after 10 cycles -> serdes_rx_reset high exactly 64 cycles; link_up=1 after STABLE_CYCLES good cycles; state=4; retry_count=0.
- block_lock never asserted, LOCK_TIMEOUT=1000 -> re-entry to RESET every 64+1000 cycles; retry_count increments to 3 after 3 timeouts; with RETRY_WIDTH=2 it saturates at 3.
- In LINK_UP, drop status for 1 cycle -> one-cycle link_down_event; state=2; link_up=0; relock -> LINK_UP again.
- phy_rx_error_count=100 for 5 cycles in LINK_UP -> error_total=500; preload near 2^32-50 then add 100 -> 0xFFFFFFFF; clear_counters together with error 7 -> error_total=0.
- Same cycle: enable=0 and phy_rx_reset_req=1 in LINK_UP -> DISABLED, retry unchanged, link_down_event=1; rst asserted mid-WAIT_STABLE -> all outputs at reset values immediately.
- With ETH_PHY_LINK_CTRL_PRBS_EN: cfg_prbs_enable=1 in LINK_UP -> both prbs enables 1 and state=5; block_lock=0 is ignored; cfg_prbs_enable=0 -> RESET and prbs enables 0.
